// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for jk_mod_counter: count controls in, JK cell
// state, per-bit J/K commands and wrap reporting out.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             tc;
  logic             wrap_pulse;
  logic [WRAPW-1:0] wrap_cnt;

  modport master (
    output en, up_dn, load, load_val,
    input  Q, Qbar, j_vec, k_vec, tc, wrap_pulse, wrap_cnt
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output Q, Qbar, j_vec, k_vec, tc, wrap_pulse, wrap_cnt
  );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter modelled as a bank of JK cells clocked on the
// falling edge; exposes the J/K commands it applies and counts wraps.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int WRAPW   = 8
) (
  input  logic               clk,
  input  logic               clear_n,
  jk_mod_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);
  localparam logic [WRAPW-1:0] ONE_W   = WRAPW'(1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] clamp;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             set_reset;
  logic             tc;
  logic             wrap_pulse;
  logic [WRAPW-1:0] wrap_cnt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    target    = q;
    set_reset = 1'b0;
    clamp     = ({1'b0, bus.load_val} >= MOD_EXT) ? MAX_Q : bus.load_val;
    tc        = bus.en & ~bus.load &
                ((bus.up_dn & (q == MAX_Q)) | (~bus.up_dn & (q == '0)));

    if (bus.load) begin
      target    = clamp;
      set_reset = 1'b1;
    end else if (bus.en) begin
      if (tc) begin
        target    = bus.up_dn ? '0 : MAX_Q;
        set_reset = 1'b1;
      end else begin
        target = bus.up_dn ? (q + ONE_Q) : (q - ONE_Q);
      end
    end

    // Wraps and loads drive cells in set/reset form; ordinary steps toggle only changing bits.
    if (set_reset) begin
      j = target;
      k = ~target;
    end else begin
      j = q ^ target;
      k = q ^ target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all cells update together on the edge.
  always_ff @(negedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q          <= '0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      q          <= (j & ~q) | (~k & q);
      wrap_pulse <= tc;
      if (tc && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + ONE_W;
      end
    end
  end

  assert property (@(negedge clk) disable iff (!clear_n) ({1'b0, q} < MOD_EXT));

  assign bus.Q          = q;
  assign bus.Qbar       = ~q;
  assign bus.j_vec      = j;
  assign bus.k_vec      = k;
  assign bus.tc         = tc;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.wrap_cnt   = wrap_cnt;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: three instances (mod 10, mod 10 with a
// 2-bit wrap counter, full-binary mod 16) driven from directed vector tables.
module tb_jk_mod_counter;

  logic clk;
  logic clear_n;

  jk_mod_counter_if #(.WIDTH(4), .WRAPW(8)) if_a ();
  jk_mod_counter_if #(.WIDTH(4), .WRAPW(2)) if_b ();
  jk_mod_counter_if #(.WIDTH(4), .WRAPW(8)) if_c ();

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(8)) u_a (.clk(clk), .clear_n(clear_n), .bus(if_a));
  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .WRAPW(2)) u_b (.clk(clk), .clear_n(clear_n), .bus(if_b));
  jk_mod_counter #(.WIDTH(4), .MODULUS(16), .WRAPW(8)) u_c (.clk(clk), .clear_n(clear_n), .bus(if_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int    sel;
    bit    rst;
    bit    ld;
    bit    en;
    bit    ud;
    int    lv;
    int    q;
    bit    tc;
    string tag;
  } vec_t;

  typedef struct {
    int    sel;
    int    q;
    int    j;
    int    k;
    int    tc;
    int    wp;
    int    wc;
    string tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  int cur_q[3];
  int cur_wp[3];
  int cur_wc[3];
  int wc_max[3] = '{255, 3, 255};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input int sel, input bit ld, input bit en, input bit ud,
                     input int lv, input int q, input bit tc, input string tag);
    vec_t v;
    v.sel = sel; v.rst = 1'b0; v.ld = ld; v.en = en; v.ud = ud;
    v.lv = lv; v.q = q; v.tc = tc; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic add_rst(input int sel, input string tag);
    vec_t v;
    v.sel = sel; v.rst = 1'b1; v.ld = 1'b0; v.en = 1'b0; v.ud = 1'b0;
    v.lv = 0; v.q = 0; v.tc = 1'b0; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic drive(input int sel, input bit ld, input bit en, input bit ud, input int lv);
    if_a.load = 1'b0; if_a.en = 1'b0; if_a.up_dn = 1'b0; if_a.load_val = '0;
    if_b.load = 1'b0; if_b.en = 1'b0; if_b.up_dn = 1'b0; if_b.load_val = '0;
    if_c.load = 1'b0; if_c.en = 1'b0; if_c.up_dn = 1'b0; if_c.load_val = '0;
    case (sel)
      0: begin if_a.load = ld; if_a.en = en; if_a.up_dn = ud; if_a.load_val = 4'(lv); end
      1: begin if_b.load = ld; if_b.en = en; if_b.up_dn = ud; if_b.load_val = 4'(lv); end
      default: begin if_c.load = ld; if_c.en = en; if_c.up_dn = ud; if_c.load_val = 4'(lv); end
    endcase
  endtask

  // Monitor: mid-cycle (rising edge) compare of the selected instance.
  initial begin
    exp_t e;
    int aq, aqb, aj, ak, atc, awp, awc;
    forever begin
      @(posedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        case (e.sel)
          0: begin
            aq = int'(if_a.Q); aqb = int'(if_a.Qbar); aj = int'(if_a.j_vec); ak = int'(if_a.k_vec);
            atc = int'(if_a.tc); awp = int'(if_a.wrap_pulse); awc = int'(if_a.wrap_cnt);
          end
          1: begin
            aq = int'(if_b.Q); aqb = int'(if_b.Qbar); aj = int'(if_b.j_vec); ak = int'(if_b.k_vec);
            atc = int'(if_b.tc); awp = int'(if_b.wrap_pulse); awc = int'(if_b.wrap_cnt);
          end
          default: begin
            aq = int'(if_c.Q); aqb = int'(if_c.Qbar); aj = int'(if_c.j_vec); ak = int'(if_c.k_vec);
            atc = int'(if_c.tc); awp = int'(if_c.wrap_pulse); awc = int'(if_c.wrap_cnt);
          end
        endcase
        check({e.tag, ".Q"},          aq,  e.q);
        check({e.tag, ".Qbar"},       aqb, (~e.q) & 15);
        check({e.tag, ".j_vec"},      aj,  e.j);
        check({e.tag, ".k_vec"},      ak,  e.k);
        check({e.tag, ".tc"},         atc, e.tc);
        check({e.tag, ".wrap_pulse"}, awp, e.wp);
        check({e.tag, ".wrap_cnt"},   awc, e.wc);
      end
    end
  end

  // Stimulus: applies one vector per falling edge and queues what must be seen before the next.
  initial begin
    int t1_q[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int t1_tc[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int t2_q[6]   = '{9, 8, 7, 6, 5, 4};
    int t2_tc[6]  = '{1, 0, 0, 0, 0, 0};
    int t4_q[7]   = '{1, 2, 3, 4, 5, 6, 7};
    vec_t v;
    exp_t e;
    int   mask;

    clear_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    for (int d = 0; d < 3; d++) begin
      cur_q[d] = 0; cur_wp[d] = 0; cur_wc[d] = 0;
    end

    // Up count from reset: 1..9, wrap to 0, then 1, 2.
    for (int i = 0; i < 12; i++) add(0, 1'b0, 1'b1, 1'b1, 0, t1_q[i], t1_tc[i] != 0, "t1_up");
    add(0, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0, "t1_hold");

    // Load clamp, load over enable, hold, direction change at the top count.
    add(0, 1'b1, 1'b0, 1'b1, 13, 9, 1'b0, "t3_clamp13");
    add(0, 1'b1, 1'b1, 1'b1, 4,  4, 1'b0, "t3_load_en");
    for (int i = 0; i < 4; i++) add(0, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0, "t3_hold");
    add(0, 1'b1, 1'b0, 1'b1, 10, 9, 1'b0, "t3_clamp10");
    add(0, 1'b0, 1'b1, 1'b0, 0,  8, 1'b0, "t3_dir_at_max");
    add(0, 1'b0, 1'b0, 1'b0, 0,  8, 1'b0, "t3_hold8");

    // Down count from reset: 0 wraps to 9, then 8..4.
    add_rst(0, "t2_rst");
    for (int i = 0; i < 6; i++) add(0, 1'b0, 1'b1, 1'b0, 0, t2_q[i], t2_tc[i] != 0, "t2_down");
    add(0, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0, "t2_hold");

    // Asynchronous reset at Q=7, then counting resumes from 0.
    add_rst(0, "t4_rst0");
    for (int i = 0; i < 7; i++) add(0, 1'b0, 1'b1, 1'b1, 0, t4_q[i], 1'b0, "t4_up");
    add(0, 1'b0, 1'b0, 1'b1, 0, 7, 1'b0, "t4_at7");
    add_rst(0, "t4_mid_rst");
    add(0, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0, "t4_after");
    add(0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, "t4_hold");

    // 2-bit wrap counter: 50 up edges give 5 wraps, count sticks at 3.
    for (int i = 0; i < 50; i++) add(1, 1'b0, 1'b1, 1'b1, 0, (i + 1) % 10, (i % 10) == 9, "t5_up");
    add(1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, "t5_hold");

    // Full binary modulus: natural rollover 15->0, and 0->15 going down.
    for (int i = 0; i < 16; i++) add(2, 1'b0, 1'b1, 1'b1, 0, (i + 1) % 16, i == 15, "t6_up");
    add(2, 1'b0, 1'b1, 1'b0, 0, 15, 1'b1, "t6_down_wrap");
    add(2, 1'b0, 1'b0, 1'b0, 0, 15, 1'b0, "t6_hold");

    mask = 15;
    while (vecs.size() != 0) begin
      v = vecs.pop_front();
      @(negedge clk);
      #1;
      e.sel = v.sel;
      e.tag = v.tag;
      if (v.rst) begin
        clear_n = 1'b0;
        drive(v.sel, 1'b0, 1'b0, 1'b0, 0);
        for (int d = 0; d < 3; d++) begin
          cur_q[d] = 0; cur_wp[d] = 0; cur_wc[d] = 0;
        end
        e.q = 0; e.j = 0; e.k = 0; e.tc = 0; e.wp = 0; e.wc = 0;
        sb.push_back(e);
      end else begin
        clear_n = 1'b1;
        drive(v.sel, v.ld, v.en, v.ud, v.lv);
        e.q  = cur_q[v.sel];
        e.tc = v.tc ? 1 : 0;
        e.wp = cur_wp[v.sel];
        e.wc = cur_wc[v.sel];
        if (v.ld || v.tc) begin
          e.j = v.q;
          e.k = (~v.q) & mask;
        end else if (v.en) begin
          e.j = cur_q[v.sel] ^ v.q;
          e.k = cur_q[v.sel] ^ v.q;
        end else begin
          e.j = 0;
          e.k = 0;
        end
        sb.push_back(e);
        for (int d = 0; d < 3; d++) cur_wp[d] = 0;
        if (v.tc) begin
          cur_wp[v.sel] = 1;
          if (cur_wc[v.sel] < wc_max[v.sel]) cur_wc[v.sel] = cur_wc[v.sel] + 1;
        end
        cur_q[v.sel] = v.q;
      end
    end

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
